// File: rtl/pwm_dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_pkg
//  Description : Shared types and helpers for the multi-channel PWM DAC.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_dac_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTRE = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // A single channel still needs a 1-bit select so the port exists.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dac_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_mc_if
//  Description : Host-side control/write bus and PWM outputs of pwm_dac_mc.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_dac_mc_if
    import pwm_dac_pkg::*;
#(
    parameter int N       = 8,
    parameter int CH      = 4,
    parameter int PRESC_W = 8
) ();

    localparam int CH_W = ch_idx_w(CH);

    logic [PRESC_W-1:0] prescale;
    logic               mode_in;
    logic [CH-1:0]      ch_en;
    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic [N-1:0]       wr_data;
    logic [CH-1:0]      pwm_out;
    logic               period_tick;

    modport master (
        output prescale, mode_in, ch_en, wr_en, wr_ch, wr_data,
        input  pwm_out, period_tick
    );

    modport slave (
        input  prescale, mode_in, ch_en, wr_en, wr_ch, wr_data,
        output pwm_out, period_tick
    );

endinterface
`default_nettype wire

// File: rtl/pwm_period_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_period_gen
//  Description : Shared prescaler, up / up-down period counter and commit detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_gen
    import pwm_dac_pkg::*;
#(
    parameter int N       = 8,
    parameter int PRESC_W = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [PRESC_W-1:0] prescale_i,
    input  wire logic               mode_i,
    output logic      [N-1:0]       ctr_o,
    output logic                    tick_o,
    output logic                    commit_o
);

    localparam logic [N-1:0] c_max  = '1;
    localparam logic [N-1:0] c_one  = N'(1);
    localparam logic [N-1:0] c_zero = '0;

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [N-1:0]       ctr_q, ctr_d;
    pwm_dir_e           dir_q, dir_d;
    pwm_mode_e          mode_q, mode_d;
    logic               w_tick, w_boundary, w_commit;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt_q <= '0;
            ctr_q       <= '0;
            dir_q       <= DIR_UP;
            mode_q      <= PWM_EDGE;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            ctr_q       <= ctr_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        w_tick      = (presc_cnt_q == prescale_i);
        presc_cnt_d = w_tick ? '0 : presc_cnt_q + PRESC_W'(1);

        // ctr==0 while falling only occurs when MAX==1 (no 1..MAX-1 descent).
        if (mode_q == PWM_EDGE) begin
            w_boundary = (ctr_q == c_max);
        end else begin
            w_boundary = (dir_q == DIR_DOWN) && ((ctr_q == c_one) || (ctr_q == c_zero));
        end
        w_commit = w_tick & w_boundary & ~reset;

        ctr_d  = ctr_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (w_commit) begin
            ctr_d  = '0;
            dir_d  = DIR_UP;
            mode_d = pwm_mode_e'(mode_i);
        end else if (w_tick) begin
            if (mode_q == PWM_EDGE) begin
                ctr_d = ctr_q + N'(1);
            end else if (dir_q == DIR_UP) begin
                if (ctr_q == c_max) begin
                    dir_d = DIR_DOWN;
                    ctr_d = ctr_q - N'(1);
                end else begin
                    ctr_d = ctr_q + N'(1);
                end
            end else begin
                ctr_d = ctr_q - N'(1);
            end
        end
    end

    assign ctr_o    = ctr_q;
    assign tick_o   = w_tick;
    assign commit_o = w_commit;

endmodule
`default_nettype wire

// File: rtl/pwm_dac_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_dac_mc
//  Description : Multi-channel PWM DAC with double-buffered duties per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac_mc
    import pwm_dac_pkg::*;
#(
    parameter int N       = 8,
    parameter int CH      = 4,
    parameter int PRESC_W = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    pwm_dac_mc_if.slave host
);

    localparam int c_ch_w = ch_idx_w(CH);

    logic [N-1:0]  w_ctr;
    logic          w_unused_tick;
    logic          w_commit;
    logic [CH-1:0] w_pwm;

    pwm_period_gen #(
        .N       (N),
        .PRESC_W (PRESC_W)
    ) u_period_gen (
        .clk        (clk),
        .reset      (reset),
        .prescale_i (host.prescale),
        .mode_i     (host.mode_in),
        .ctr_o      (w_ctr),
        .tick_o     (w_unused_tick),
        .commit_o   (w_commit)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [c_ch_w-1:0] c_idx = c_ch_w'(i);

        logic [N-1:0] shadow_q;
        logic [N-1:0] active_q;
        logic         pwm_q;

        // Non-blocking copy means a same-cycle write lands only in the shadow.
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_q <= '0;
                active_q <= '0;
                pwm_q    <= 1'b0;
            end else begin
                if (host.wr_en && (host.wr_ch == c_idx)) begin
                    shadow_q <= host.wr_data;
                end
                if (w_commit) begin
                    active_q <= shadow_q;
                end
                pwm_q <= host.ch_en[i] & (w_ctr < active_q);
            end
        end

        assign w_pwm[i] = pwm_q;
    end

    assign host.pwm_out     = w_pwm;
    assign host.period_tick = w_commit;

endmodule
`default_nettype wire

// File: tb/tb_pwm_dac_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_dac_mc
//  Description : Directed self-checking bench for pwm_dac_mc (N=8, CH=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_dac_mc;

    localparam int N       = 8;
    localparam int CH      = 3;
    localparam int PRESC_W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pwm_dac_mc_if #(.N(N), .CH(CH), .PRESC_W(PRESC_W)) host ();

    pwm_dac_mc #(.N(N), .CH(CH), .PRESC_W(PRESC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .host  (host)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int ch, input int val);
        host.wr_en   = 1'b1;
        host.wr_ch   = ch[1:0];
        host.wr_data = val[7:0];
        @(negedge clk);
        host.wr_en   = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int found;
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            @(negedge clk);
            if (host.period_tick) found = 1;
        end
        check_eq(tag, found, 1);
    endtask

    // Entered at the negedge one clock after a commit; returns at the same
    // point one period later. Counts high clocks over exactly one period.
    task automatic run_period(input string tag, input int p,
                              input int wa, input int cha, input int va,
                              input int wb, input int chb, input int vb,
                              input int e0, input int e1, input int e2,
                              input int esp);
        int hi [CH];
        int sp;
        sp = 0;
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int i = 2; i <= p + 1; i++) begin
            @(negedge clk);
            host.wr_en = 1'b0;
            if (i == wa) begin
                host.wr_en = 1'b1; host.wr_ch = cha[1:0]; host.wr_data = va[7:0];
            end
            if (i == wb) begin
                host.wr_en = 1'b1; host.wr_ch = chb[1:0]; host.wr_data = vb[7:0];
            end
            for (int c = 0; c < CH; c++) hi[c] += int'(host.pwm_out[c]);
            if (host.period_tick && sp == 0) sp = i;
        end
        check_eq({tag, "_hi0"}, hi[0], e0);
        check_eq({tag, "_hi1"}, hi[1], e1);
        check_eq({tag, "_hi2"}, hi[2], e2);
        check_eq({tag, "_period"}, sp, esp);
    endtask

    initial begin
        int cnt;
        int highs;

        reset        = 1'b1;
        host.prescale = '0;
        host.mode_in = 1'b0;
        host.ch_en   = 3'b111;
        host.wr_en   = 1'b0;
        host.wr_ch   = '0;
        host.wr_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_pwm", int'(host.pwm_out), 0);
        check_eq("rst_tick", int'(host.period_tick), 0);
        reset = 1'b0;

        wr(0, 64);
        wr(1, 255);
        wr(2, 0);
        wait_tick("tick_first");
        @(negedge clk);

        // Edge mode, prescale 0: duty 64, MAX and 0
        run_period("edge64", 256, 0, 0, 0, 0, 0, 0, 64, 255, 0, 256);

        // Two writes in one period: old duty holds, last write applies next
        run_period("upd_old", 256, 20, 0, 200, 40, 0, 50, 64, 255, 0, 256);
        run_period("upd_new", 256, 0, 0, 0, 0, 0, 0, 50, 255, 0, 256);

        // Write landing in the commit cycle is deferred one period
        run_period("set10", 256, 5, 0, 10, 0, 0, 0, 50, 255, 0, 256);
        wait_tick("tick_cc");
        host.wr_en = 1'b1; host.wr_ch = 2'd0; host.wr_data = 8'd90;
        @(negedge clk);
        host.wr_en = 1'b0;
        run_period("cc_old", 256, 0, 0, 0, 0, 0, 0, 10, 255, 0, 256);
        run_period("cc_new", 256, 5, 0, 128, 0, 0, 0, 90, 255, 0, 256);

        // Prescale 3: every counter step lasts 4 clocks
        host.prescale = 8'd3;
        run_period("presc3", 1024, 0, 0, 0, 0, 0, 0, 512, 1020, 0, 1024);
        host.prescale = 8'd0;

        // Disabling a channel takes effect on the next clock
        host.ch_en = 3'b101;
        run_period("chen", 256, 5, 0, 100, 0, 0, 0, 128, 0, 0, 256);
        host.ch_en = 3'b111;

        // Mode request mid-period only applies after the edge boundary
        host.mode_in = 1'b1;
        run_period("edge_pre", 256, 0, 0, 0, 0, 0, 0, 100, 255, 0, 256);
        run_period("ctr1", 510, 0, 0, 0, 0, 0, 0, 199, 509, 0, 510);
        host.mode_in = 1'b0;
        run_period("ctr2", 510, 0, 0, 0, 0, 0, 0, 199, 509, 0, 510);
        run_period("edge_back", 256, 0, 0, 0, 0, 0, 0, 100, 255, 0, 256);

        // Reset while ch0 is high, with an out-of-range write alongside
        repeat (20) @(negedge clk);
        check_eq("pre_rst_pwm0", int'(host.pwm_out[0]), 1);
        reset = 1'b1;
        host.wr_en = 1'b1; host.wr_ch = 2'd3; host.wr_data = 8'd77;
        @(negedge clk);
        check_eq("midrst_pwm", int'(host.pwm_out), 0);
        check_eq("midrst_tick", int'(host.period_tick), 0);
        reset = 1'b0;
        host.wr_en = 1'b0;

        cnt = 0;
        highs = 0;
        for (int i = 1; i <= 400 && cnt == 0; i++) begin
            @(negedge clk);
            highs += int'(host.pwm_out[0]) + int'(host.pwm_out[1]) + int'(host.pwm_out[2]);
            if (host.period_tick) cnt = i;
        end
        check_eq("postrst_first_tick", cnt, 255);
        check_eq("postrst_highs", highs, 0);
        @(negedge clk);

        run_period("post_rst", 256, 10, 0, 30, 20, 1, 40, 0, 0, 0, 256);
        run_period("inval", 256, 10, 3, 200, 0, 0, 0, 30, 40, 0, 256);
        run_period("inval_chk", 256, 0, 0, 0, 0, 0, 0, 30, 40, 0, 256);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
